picomips_sequencer: RTL and testbench

Multi-cycle control unit for the picoMIPS datapath.
- Holds the program counter and fetches instructions from an asynchronous program ROM.
- Latches each instruction into an instruction register and drives the datapath controls: writeReg, aluFunc, aluImmediate, opD, opS, opT.
- Runs the switch-input handshake (wait for press, wait for release) and generates the display load strobe.
- Sits between program ROM, board switches and dataPath; it is the only writer of datapath control.

---
 rtl/picomips_sequencer_if.sv | 36 +++
 rtl/picomips_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_picomips_sequencer.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/picomips_sequencer_if.sv
// Bus between the picoMIPS sequencer and its surroundings: program ROM fetch,
// board switches, and the datapath control lines.
interface picomips_sequencer_if #(
  parameter int N       = 8,
  parameter int R_SIZE  = 3,
  parameter int PC_SIZE = 5
);
  localparam int I_SIZE = 4 + 2 * R_SIZE + N;

  // Program ROM
  logic [PC_SIZE-1:0] instrAddr;
  logic [I_SIZE-1:0]  instr;

  // Board switches
  logic               swReady;
  logic [N-1:0]       swData;

  // Datapath control; aluFunc carries a cpuConfig::aluFunc_t encoding
  logic               writeReg;
  logic [1:0]         aluFunc;
  logic               aluImmediate;
  logic [R_SIZE-1:0]  opD;
  logic [R_SIZE-1:0]  opS;
  logic [N-1:0]       opT;
  logic               displayLoad;

  modport master (
    output instrAddr, writeReg, aluFunc, aluImmediate, opD, opS, opT, displayLoad,
    input  instr, swReady, swData
  );

  modport slave (
    input  instrAddr, writeReg, aluFunc, aluImmediate, opD, opS, opT, displayLoad,
    output instr, swReady, swData
  );
endinterface

// File: rtl/picomips_sequencer.sv
// picoMIPS multi-cycle control unit: PC, instruction register, switch handshake
// and every datapath control strobe.
package cpuConfig;
  typedef enum logic [1:0] {
    ALU_ADD   = 2'd0,
    ALU_SUB   = 2'd1,
    ALU_MUL   = 2'd2,
    ALU_PASSB = 2'd3
  } aluFunc_t;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_ADDI = 4'd2,
    OP_SUB  = 4'd3,
    OP_SUBI = 4'd4,
    OP_MUL  = 4'd5,
    OP_MULI = 4'd6,
    OP_IN   = 4'd7,
    OP_OUT  = 4'd8,
    OP_JMP  = 4'd9,
    OP_HALT = 4'd15
  } opcode_t;
endpackage

module picomips_sequencer #(
  parameter int N       = 8,
  parameter int R_SIZE  = 3,
  parameter int PC_SIZE = 5
) (
  input  logic                   clk,
  input  logic                   nReset,
  picomips_sequencer_if.master   bus,
  output logic                   halted
);
  import cpuConfig::*;

  typedef enum logic [2:0] {
    S_FETCH,
    S_EXEC,
    S_WAIT_PRESS,
    S_WAIT_RELEASE,
    S_HALT
  } state_t;

  typedef struct packed {
    logic [3:0]        opcode;
    logic [R_SIZE-1:0] d;
    logic [R_SIZE-1:0] s;
    logic [N-1:0]      imm;
  } instr_t;

  state_t             state_q, state_d;
  logic [PC_SIZE-1:0] pc_q, pc_d;
  instr_t             ir_q, ir_d;
  logic               sw_meta_q, sw_sync_q;

  logic [PC_SIZE-1:0] pc_inc;
  logic               write_reg;
  aluFunc_t           alu_func;
  logic               alu_immediate;
  logic [R_SIZE-1:0]  op_d;
  logic [R_SIZE-1:0]  op_s;
  logic [N-1:0]       op_t;
  logic               display_load;
  logic               halted_o;

  assign pc_inc = pc_q + PC_SIZE'(1);

  // ---------------------------------------------------------------------------
  // State register, including the two-flop swReady synchronizer
  // ---------------------------------------------------------------------------
  // NOTE: non-blocking assignments here so every flop samples the pre-edge value.
  always_ff @(posedge clk) begin
    if (!nReset) begin
      state_q   <= S_FETCH;
      pc_q      <= '0;
      ir_q      <= '0;
      sw_meta_q <= 1'b0;
      sw_sync_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      sw_meta_q <= bus.swReady;
      sw_sync_q <= sw_meta_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and PC/IR update
  // ---------------------------------------------------------------------------
  // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;

    unique case (state_q)
      S_FETCH: begin
        ir_d    = instr_t'(bus.instr);
        state_d = S_EXEC;
      end

      S_EXEC: begin
        state_d = S_FETCH;
        case (ir_q.opcode)
          OP_JMP:  pc_d    = ir_q.imm[PC_SIZE-1:0];
          OP_IN:   state_d = S_WAIT_PRESS;
          OP_HALT: state_d = S_HALT;
          default: pc_d    = pc_inc;
        endcase
      end

      S_WAIT_PRESS: begin
        if (sw_sync_q) begin
          pc_d    = pc_inc;
          state_d = S_WAIT_RELEASE;
        end
      end

      // A button still held after the write must be released before moving on.
      S_WAIT_RELEASE: begin
        if (!sw_sync_q) state_d = S_FETCH;
      end

      S_HALT: state_d = S_HALT;

      default: state_d = S_FETCH;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath control decode
  // ---------------------------------------------------------------------------
  always_comb begin
    write_reg     = 1'b0;
    alu_func      = ALU_ADD;
    alu_immediate = 1'b0;
    op_d          = '0;
    op_s          = '0;
    op_t          = '0;
    display_load  = 1'b0;
    halted_o      = 1'b0;

    unique case (state_q)
      S_EXEC: begin
        op_d = ir_q.d;
        op_s = ir_q.s;
        op_t = ir_q.imm;
        case (ir_q.opcode)
          OP_ADD:  begin write_reg = 1'b1; alu_func = ALU_ADD; end
          OP_ADDI: begin write_reg = 1'b1; alu_func = ALU_ADD; alu_immediate = 1'b1; end
          OP_SUB:  begin write_reg = 1'b1; alu_func = ALU_SUB; end
          OP_SUBI: begin write_reg = 1'b1; alu_func = ALU_SUB; alu_immediate = 1'b1; end
          OP_MUL:  begin write_reg = 1'b1; alu_func = ALU_MUL; end
          OP_MULI: begin write_reg = 1'b1; alu_func = ALU_MUL; alu_immediate = 1'b1; end
          // D + 0 routes register D onto displayResult without a register write.
          OP_OUT: begin
            alu_func      = ALU_ADD;
            alu_immediate = 1'b1;
            op_t          = '0;
            display_load  = 1'b1;
          end
          default: ;
        endcase
      end

      S_WAIT_PRESS: begin
        op_d = ir_q.d;
        if (sw_sync_q) begin
          write_reg     = 1'b1;
          alu_immediate = 1'b1;
          alu_func      = ALU_PASSB;
          op_t          = bus.swData;
        end
      end

      S_HALT: halted_o = 1'b1;

      default: ;
    endcase
  end

  assign bus.instrAddr    = pc_q;
  assign bus.writeReg     = write_reg;
  assign bus.aluFunc      = alu_func;
  assign bus.aluImmediate = alu_immediate;
  assign bus.opD          = op_d;
  assign bus.opS          = op_s;
  assign bus.opT          = op_t;
  assign bus.displayLoad  = display_load;
  assign halted           = halted_o;

endmodule

// File: tb/tb_picomips_sequencer.sv
// Bench for picomips_sequencer: an instruction-level interpreter predicts every
// cycle's outputs; a tiny register file checks the values the controls produce.
module tb_picomips_sequencer;
  import cpuConfig::*;

  localparam int N       = 8;
  localparam int R_SIZE  = 3;
  localparam int PC_SIZE = 5;
  localparam int I_SIZE  = 4 + 2 * R_SIZE + N;
  localparam int DEPTH   = 1 << PC_SIZE;
  localparam int MAXC    = 256;

  typedef struct packed {
    logic [4:0] addr;
    logic       wr;
    logic [1:0] func;
    logic       imm;
    logic [2:0] d;
    logic [2:0] s;
    logic [7:0] t;
    logic       disp;
    logic       halted;
  } obs_t;

  logic clk = 1'b0;
  logic nReset = 1'b0;
  logic halted;

  picomips_sequencer_if #(.N(N), .R_SIZE(R_SIZE), .PC_SIZE(PC_SIZE)) bus ();

  picomips_sequencer #(.N(N), .R_SIZE(R_SIZE), .PC_SIZE(PC_SIZE)) dut (
    .clk    (clk),
    .nReset (nReset),
    .bus    (bus),
    .halted (halted)
  );

  always #5 clk = ~clk;

  logic [I_SIZE-1:0] rom [DEPTH];
  assign bus.instr = rom[bus.instrAddr];

  logic       sw_tab    [MAXC];
  obs_t       exp_q     [$];
  logic [4:0] hist_addr [MAXC];
  logic       hist_wr   [MAXC];
  logic       hist_halt [MAXC];
  logic [7:0] hist_t    [MAXC];
  logic [7:0] regs      [8];
  int         wr_cnt, disp_cyc;
  logic [7:0] disp_val;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [I_SIZE-1:0] enc(input int op, input int d, input int s, input int imm);
    return {4'(op), 3'(d), 3'(s), 8'(imm)};
  endfunction

  // Synchronized swReady seen in cycle c: raw value two cycles earlier, 0 right after reset.
  function automatic logic sync_at(input int c);
    return (c >= 3) ? sw_tab[c-2] : 1'b0;
  endfunction

  // Interpret the program from pc=0, one entry per cycle, until n cycles are known.
  function automatic void gen(input int n, input logic [7:0] swdata);
    int   pc;
    obs_t e;
    pc = 0;
    exp_q.delete();
    while (exp_q.size() < n) begin
      logic [I_SIZE-1:0] w;
      int op;
      w  = rom[pc];
      op = int'(w[17:14]);
      e = '0;
      e.addr = 5'(pc);
      exp_q.push_back(e);
      e.d = w[13:11];
      e.s = w[10:8];
      e.t = w[7:0];
      if (op >= 1 && op <= 6) begin
        e.wr   = 1'b1;
        e.imm  = (op % 2 == 0);
        e.func = (op <= 2) ? ALU_ADD : (op <= 4) ? ALU_SUB : ALU_MUL;
        pc = (pc + 1) % DEPTH;
      end else if (op == 8) begin
        e.func = ALU_ADD;
        e.imm  = 1'b1;
        e.t    = '0;
        e.disp = 1'b1;
        pc = (pc + 1) % DEPTH;
      end else if (op == 9) begin
        pc = int'(w[7:0]) % DEPTH;
      end else if (op != 7 && op != 15) begin
        pc = (pc + 1) % DEPTH;
      end
      exp_q.push_back(e);

      if (op == 7) begin
        while (exp_q.size() < n) begin
          e = '0;
          e.addr = 5'(pc);
          e.d    = w[13:11];
          if (sync_at(exp_q.size() + 1)) begin
            e.wr   = 1'b1;
            e.imm  = 1'b1;
            e.func = ALU_PASSB;
            e.t    = swdata;
            exp_q.push_back(e);
            pc = (pc + 1) % DEPTH;
            break;
          end
          exp_q.push_back(e);
        end
        while (exp_q.size() < n) begin
          logic released;
          released = !sync_at(exp_q.size() + 1);
          e = '0;
          e.addr = 5'(pc);
          exp_q.push_back(e);
          if (released) break;
        end
      end

      if (op == 15) begin
        while (exp_q.size() < n) begin
          e = '0;
          e.addr   = 5'(pc);
          e.halted = 1'b1;
          exp_q.push_back(e);
        end
      end
    end
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.addr   = bus.instrAddr;
    o.wr     = bus.writeReg;
    o.func   = bus.aluFunc;
    o.imm    = bus.aluImmediate;
    o.d      = bus.opD;
    o.s      = bus.opS;
    o.t      = bus.opT;
    o.disp   = bus.displayLoad;
    o.halted = halted;
    return o;
  endfunction

  // Reset for rst_hold edges with swReady high, then compare n cycles against the model.
  task automatic run(input string name, input int n, input logic [7:0] swdata, input int rst_hold);
    obs_t o;
    logic [7:0] a, b, r;
    nReset = 1'b0;
    bus.swReady = 1'b1;
    bus.swData  = swdata;
    repeat (rst_hold) @(posedge clk);
    #1;
    check($sformatf("%s:reset_outputs", name), 32'(sample()), 32'(obs_t'('0)));
    gen(n, swdata);
    for (int i = 0; i < 8; i++) regs[i] = '0;
    wr_cnt = 0; disp_cyc = 0; disp_val = '0;
    nReset = 1'b1;
    for (int c = 1; c <= n; c++) begin
      bus.swReady = sw_tab[c];
      o = sample();
      hist_addr[c] = o.addr;
      hist_wr[c]   = o.wr;
      hist_halt[c] = o.halted;
      hist_t[c]    = o.t;
      check($sformatf("%s:cycle%0d", name, c), 32'(o), 32'(exp_q[c-1]));
      a = regs[o.d];
      b = o.imm ? o.t : regs[o.s];
      case (o.func)
        ALU_ADD: r = a + b;
        ALU_SUB: r = a - b;
        ALU_MUL: r = a * b;
        default: r = b;
      endcase
      if (o.disp) begin disp_cyc = c; disp_val = r; end
      if (o.wr) begin regs[o.d] = r; wr_cnt++; end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_prog();
    for (int i = 0; i < DEPTH; i++) rom[i] = '0;
    for (int i = 0; i < MAXC; i++) sw_tab[i] = 1'b0;
  endtask

  initial begin
    int w_early;
    bus.swReady = 1'b0;
    bus.swData  = '0;

    // ALU sequence: writes at cycles 2,4,6; display of 8 at cycle 8
    clear_prog();
    rom[0] = enc(2, 1, 0, 5);
    rom[1] = enc(2, 2, 0, 3);
    rom[2] = enc(1, 1, 2, 0);
    rom[3] = enc(8, 1, 0, 0);
    run("alu", 12, 8'h00, 3);
    check("alu:first_addr", 32'(hist_addr[1]), 32'd0);
    check("alu:wr_pattern", 32'({hist_wr[8], hist_wr[7], hist_wr[6], hist_wr[5],
                                 hist_wr[4], hist_wr[3], hist_wr[2], hist_wr[1]}), 32'h2A);
    check("alu:disp_cycle", 32'(disp_cyc), 32'd8);
    check("alu:disp_value", 32'(disp_val), 32'd8);

    // IN handshake: raise at 11, hold 20 cycles; ADDI after the release
    clear_prog();
    rom[0] = enc(7, 3, 0, 0);
    rom[1] = enc(2, 1, 0, 1);
    for (int c = 11; c <= 30; c++) sw_tab[c] = 1'b1;
    run("in", 40, 8'h2A, 3);
    w_early = 0;
    for (int c = 1; c <= 34; c++) if (hist_wr[c]) w_early++;
    check("in:one_write", 32'(w_early), 32'd1);
    check("in:write_cycle13", 32'(hist_wr[13]), 32'd1);
    check("in:opT_sw", 32'(hist_t[13]), 32'h2A);
    check("in:reg3", 32'(regs[3]), 32'h2A);
    check("in:next_exec_cycle35", 32'(hist_wr[35]), 32'd1);

    // Jump and pc wrap
    clear_prog();
    rom[0]  = enc(9, 0, 0, 31);
    run("jmp_nop", 8, 8'h00, 3);
    check("jmp_nop:pc_seq", 32'({hist_addr[1], hist_addr[3], hist_addr[5]}), 32'({5'd0, 5'd31, 5'd0}));
    rom[31] = enc(2, 1, 0, 1);
    run("jmp_wrap", 8, 8'h00, 3);
    check("jmp_wrap:wr_at31", 32'(hist_wr[4]), 32'd1);
    check("jmp_wrap:addr_after31", 32'(hist_addr[5]), 32'd0);

    // Undefined opcode then HALT; halted once the HALT state is entered (cycle 5)
    clear_prog();
    rom[0] = enc(12, 0, 0, 0);
    rom[1] = enc(15, 0, 0, 0);
    run("halt", 60, 8'h00, 3);
    check("halt:low_cycle4", 32'(hist_halt[4]), 32'd0);
    check("halt:high_cycle5", 32'(hist_halt[5]), 32'd1);
    check("halt:addr_stuck", 32'(hist_addr[60]), 32'd1);
    run("halt_rst", 4, 8'h00, 1);
    check("halt_rst:pc0", 32'(hist_addr[1]), 32'd0);

    // Reset while waiting for a press, with the press arriving in the same cycle
    clear_prog();
    rom[0] = enc(7, 3, 0, 0);
    run("midin_pre", 5, 8'h55, 3);
    bus.swReady = 1'b1;
    nReset = 1'b0;
    check("midin:wr_during_reset", 32'(bus.writeReg), 32'd0);
    run("midin", 8, 8'h55, 1);
    check("midin:no_writes", 32'(wr_cnt), 32'd0);

    // Random programs and switch activity
    for (int k = 0; k < 6; k++) begin
      logic lvl;
      clear_prog();
      for (int i = 0; i < DEPTH; i++) begin
        int op;
        op = int'($urandom_range(0, 15));
        if (op == 15 && $urandom_range(0, 3) != 0) op = 2;
        rom[i] = enc(op, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 255)));
      end
      lvl = 1'b0;
      for (int c = 0; c < MAXC; c++) begin
        if ($urandom_range(0, 7) == 0) lvl = ~lvl;
        sw_tab[c] = lvl;
      end
      run($sformatf("rand%0d", k), 200, 8'($urandom_range(0, 255)), 2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
